pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Pipeline control stage directly downstream of the MEM/WB pipeline register.
- Consumes the MEM/WB outputs (mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out).
- Generates per-stage stall/flush and the exception/return PC.
- Holds the control registers (status, EPC, vector, cause, interrupt mask), read by ID and written by WRCR.

Parameters:
- IRQ_CH, 8, number of external interrupt request lines.
- RESET_VECTOR, 30'h0, word address loaded into exp_vector at reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- if_busy  in  1  fetch bus access in progress
- mem_busy  in  1  MEM bus access in progress (busy of MEM stage)
- ld_hazard  in  1  load-use hazard detected by ID
- irq  in  IRQ_CH  level interrupt requests
- creg_rd_addr  in  5  control register read address from ID
- creg_rd_data  out  32  control register read data, combinational
- mem_pc  in  30  MEM/WB word PC
- mem_en  in  1  MEM/WB valid
- mem_br_flag  in  1  instruction is in a branch delay slot
- mem_ctrl_op  in  2  NOP=0, WRCR=1, EXRT=2
- mem_dst_addr  in  5  control register write address
- mem_gpr_we_  in  1  unused except for trace; kept for stage symmetry
- mem_exp_code  in  3  exception code
- mem_out  in  32  WRCR write data
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  stage stalls
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  stage flushes
- new_pc  out  30  redirect target, valid while if_flush=1
- exe_mode  out  1  1=kernel, 0=user
- int_detect  out  1  unmasked interrupt pending and enabled

Behaviour:
- Register reset (reset=0, async):
  - status = {int_en=0, exe_mode=1}; pre_status = 0; epc = 0.
  - exp_vector = RESET_VECTOR; cause = 0; int_mask = all ones.
- Output reset: every comb output is 0, except exe_mode=1.
- Stall:
  - stall = if_busy | mem_busy.
  - All four *_stall = stall.
  - In addition, if_stall and id_stall are also asserted by ld_hazard.
- Load hazard (no stall, no exception): id_flush=1 inserts a bubble into ID/EX; IF and ID hold.
- Exception taken when mem_en=1, stall=0, and either mem_exp_code != NO_EXP or (int_detect=1 and mem_exp_code == NO_EXP). In the interrupt case the code is EXT_INT=1.
  - Same cycle, combinational: all four *_flush=1, new_pc=exp_vector.
  - Next edge:
    - epc = mem_br_flag ? mem_pc-1 : mem_pc (30-bit wrap).
    - cause = code.
    - pre_status = status.
    - status = {int_en=0, exe_mode=1}.
- EXRT: mem_en=1, stall=0, mem_ctrl_op=EXRT, and no exception.
  - Same cycle: all flushes=1, new_pc=epc.
  - Next edge: status = pre_status.
- WRCR: mem_en=1, stall=0, mem_ctrl_op=WRCR, no exception, and exe_mode=1.
  - Writes mem_out to register mem_dst_addr at the edge.
  - Writes in user mode never occur here: ID raises PRV_VIO (6) instead.
- Priority: exception > EXRT > WRCR > ld_hazard. While stall=1, nothing is taken and no registers change.
- creg map:
  - 0 status[1:0]
  - 1 pre_status[1:0]
  - 2 epc (bits 31:2, low 2 bits 0)
  - 3 exp_vector (same format)
  - 4 cause[2:0]
  - 5 int_mask[IRQ_CH-1:0]
  - 6 irq (read-only)
  - others: read 0, writes ignored
- Read-after-write: a read in the same cycle as a write returns the old value. ID forwards from MEM.
- int_detect = int_en & |(irq & ~int_mask).
- Reset mid-stall or mid-exception: all state returns to reset values immediately. No pending redirect survives.

Optional Feature:
- Macro: PIPE_CTRL_IRQ_EN.
- When defined: irq, int_mask, creg 5/6 and int_detect are as above.
- When undefined:
  - The irq port remains but is ignored; int_detect ties to 0.
  - creg 5/6 read 0, and writes to them are ignored.
  - No EXT_INT exceptions are taken.

Decomposition:
- Shared header holds:
  - Ctrl op codes (NOP/WRCR/EXRT).
  - Exception codes: NO_EXP=0, EXT_INT=1, UNDEF=2, OVERFLOW=3, MISS_ALIGN=4, TRAP=5, PRV_VIO=6.
  - creg addresses 0–6.
  - Status bit indices.
  - Bus widths (WordAddr 30, WordData 32, RegAddr 5, CtrlOp 2, IsaExp 3).
- One sub-module, pipe_creg_file: holds the register bank, the read mux and the write/exception/EXRT update logic.
- The top holds the stall/flush/new_pc logic.

Test Plan:
- Reset release:
  - exe_mode=1, all stalls/flushes=0.
  - Reading creg 3 returns RESET_VECTOR<<2.
  - Reading creg 5 returns 0xFF.
- mem_busy=1 for 3 cycles with mem_exp_code=OVERFLOW, mem_en=1:
  - All stalls=1 for those cycles and no flush.
  - On the cycle mem_busy drops: all flushes=1, new_pc=exp_vector.
  - Next cycle: cause=3.
- Exception in a delay slot: mem_pc=30'h100, mem_br_flag=1, code=TRAP → epc=30'h0FF, pre_status=0b11 (from status 0b11), status=0b01.
- WRCR addr 5 data 0xFE in kernel mode, int_en=1, irq=0x01 → int_detect=1. The next valid instruction takes EXT_INT with cause=1.
- EXRT after the trap: new_pc=epc and flushes=1. Next edge, status is restored from pre_status.
- ld_hazard=1 with no stall: if_stall=id_stall=1, id_flush=1, ex/mem stalls and flushes=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control stage: op/exception codes, control
// register map, status bit positions and bus widths.
package pipe_ctrl_pkg;

   localparam int unsigned WordAddrW = 30;
   localparam int unsigned WordDataW = 32;
   localparam int unsigned RegAddrW  = 5;
   localparam int unsigned CtrlOpW   = 2;
   localparam int unsigned IsaExpW   = 3;

   typedef logic [WordAddrW-1:0] word_addr_t;
   typedef logic [WordDataW-1:0] word_data_t;
   typedef logic [RegAddrW-1:0]  reg_addr_t;
   typedef logic [CtrlOpW-1:0]   ctrl_op_t;
   typedef logic [IsaExpW-1:0]   isa_exp_t;

   typedef enum logic [CtrlOpW-1:0] {
      CtrlOpNop  = 2'd0,
      CtrlOpWrcr = 2'd1,
      CtrlOpExrt = 2'd2
   } ctrl_op_e;

   typedef enum logic [IsaExpW-1:0] {
      ExpNone      = 3'd0,
      ExpExtInt    = 3'd1,
      ExpUndef     = 3'd2,
      ExpOverflow  = 3'd3,
      ExpMissAlign = 3'd4,
      ExpTrap      = 3'd5,
      ExpPrvVio    = 3'd6
   } isa_exp_e;

   localparam reg_addr_t CregStatus    = 5'd0;
   localparam reg_addr_t CregPreStatus = 5'd1;
   localparam reg_addr_t CregEpc       = 5'd2;
   localparam reg_addr_t CregExpVector = 5'd3;
   localparam reg_addr_t CregCause     = 5'd4;
   localparam reg_addr_t CregIntMask   = 5'd5;
   localparam reg_addr_t CregIrq       = 5'd6;

   localparam int unsigned StatusExeModeBit = 0;
   localparam int unsigned StatusIntEnBit   = 1;

   // Kernel mode, interrupts disabled.
   localparam logic [1:0] StatusKernel = 2'b01;

   function automatic word_data_t word_addr_to_data(word_addr_t addr);
      return {addr, 2'b00};
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// MEM/WB pipeline register outputs as seen by the control stage.
// master: the MEM/WB register driving the bundle; slave: the control stage consuming it.
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   word_addr_t mem_pc;
   logic       mem_en;
   logic       mem_br_flag;
   ctrl_op_t   mem_ctrl_op;
   reg_addr_t  mem_dst_addr;
   logic       mem_gpr_we_;
   isa_exp_t   mem_exp_code;
   word_data_t mem_out;

   modport master (
      output mem_pc,
      output mem_en,
      output mem_br_flag,
      output mem_ctrl_op,
      output mem_dst_addr,
      output mem_gpr_we_,
      output mem_exp_code,
      output mem_out
   );

   modport slave (
      input mem_pc,
      input mem_en,
      input mem_br_flag,
      input mem_ctrl_op,
      input mem_dst_addr,
      input mem_gpr_we_,
      input mem_exp_code,
      input mem_out
   );

endinterface

// File: rtl/pipe_creg_file.sv
// Control register bank: status, pre_status, EPC, vector, cause and (with PIPE_CTRL_IRQ_EN)
// the interrupt mask. Updated by exception entry, EXRT and WRCR; read combinationally by ID.
module pipe_creg_file
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned IRQ_CH       = 8,
   parameter word_addr_t  RESET_VECTOR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IRQ_CH-1:0] irq_i,
   input  reg_addr_t         rd_addr_i,
   output word_data_t        rd_data_o,
   input  logic              exp_take_i,
   input  isa_exp_t          exp_code_i,
   input  word_addr_t        exp_pc_i,
   input  logic              exp_br_flag_i,
   input  logic              exrt_take_i,
   input  logic              wr_en_i,
   input  reg_addr_t         wr_addr_i,
   input  word_data_t        wr_data_i,
   output logic              exe_mode_o,
   output logic              int_detect_o,
   output word_addr_t        epc_o,
   output word_addr_t        exp_vector_o
);

   logic [1:0] status_q, status_d;
   logic [1:0] pre_status_q, pre_status_d;
   word_addr_t epc_q, epc_d;
   word_addr_t exp_vector_q, exp_vector_d;
   isa_exp_t   cause_q, cause_d;
`ifdef PIPE_CTRL_IRQ_EN
   logic [IRQ_CH-1:0] int_mask_q, int_mask_d;
`endif

   // Exception entry wins over EXRT, which wins over a register write.
   always_comb begin
      status_d     = status_q;
      pre_status_d = pre_status_q;
      epc_d        = epc_q;
      exp_vector_d = exp_vector_q;
      cause_d      = cause_q;
`ifdef PIPE_CTRL_IRQ_EN
      int_mask_d   = int_mask_q;
`endif
      if (exp_take_i) begin
         // A delay-slot instruction restarts at its branch.
         epc_d        = exp_br_flag_i ? (exp_pc_i - word_addr_t'(1)) : exp_pc_i;
         cause_d      = exp_code_i;
         pre_status_d = status_q;
         status_d     = StatusKernel;
      end else if (exrt_take_i) begin
         status_d = pre_status_q;
      end else if (wr_en_i) begin
         case (wr_addr_i)
            CregStatus:    status_d     = wr_data_i[1:0];
            CregPreStatus: pre_status_d = wr_data_i[1:0];
            CregEpc:       epc_d        = wr_data_i[WordDataW-1:2];
            CregExpVector: exp_vector_d = wr_data_i[WordDataW-1:2];
            CregCause:     cause_d      = wr_data_i[IsaExpW-1:0];
`ifdef PIPE_CTRL_IRQ_EN
            CregIntMask:   int_mask_d   = wr_data_i[IRQ_CH-1:0];
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         status_q     <= StatusKernel;
         pre_status_q <= '0;
         epc_q        <= '0;
         exp_vector_q <= RESET_VECTOR;
         cause_q      <= '0;
`ifdef PIPE_CTRL_IRQ_EN
         int_mask_q   <= '1;
`endif
      end else begin
         status_q     <= status_d;
         pre_status_q <= pre_status_d;
         epc_q        <= epc_d;
         exp_vector_q <= exp_vector_d;
         cause_q      <= cause_d;
`ifdef PIPE_CTRL_IRQ_EN
         int_mask_q   <= int_mask_d;
`endif
      end
   end

   // Reads see the pre-write value; ID forwards from MEM for same-cycle updates.
   always_comb begin
      rd_data_o = '0;
      case (rd_addr_i)
         CregStatus:    rd_data_o[1:0]         = status_q;
         CregPreStatus: rd_data_o[1:0]         = pre_status_q;
         CregEpc:       rd_data_o              = word_addr_to_data(epc_q);
         CregExpVector: rd_data_o              = word_addr_to_data(exp_vector_q);
         CregCause:     rd_data_o[IsaExpW-1:0] = cause_q;
`ifdef PIPE_CTRL_IRQ_EN
         CregIntMask:   rd_data_o[IRQ_CH-1:0]  = int_mask_q;
         CregIrq:       rd_data_o[IRQ_CH-1:0]  = irq_i;
`endif
         default: ;
      endcase
   end

`ifdef PIPE_CTRL_IRQ_EN
   assign int_detect_o = status_q[StatusIntEnBit] & (|(irq_i & ~int_mask_q));
`else
   logic unused_irq;
   assign unused_irq   = ^irq_i;
   assign int_detect_o = 1'b0;
`endif

   assign exe_mode_o   = status_q[StatusExeModeBit];
   assign epc_o        = epc_q;
   assign exp_vector_o = exp_vector_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control stage after MEM/WB: stall/flush generation, exception/EXRT redirect and
// the control register file. Build with PIPE_CTRL_IRQ_EN to enable external interrupts.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned IRQ_CH       = 8,
   parameter word_addr_t  RESET_VECTOR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_busy,
   input  logic              mem_busy,
   input  logic              ld_hazard,
   input  logic [IRQ_CH-1:0] irq,
   input  reg_addr_t         creg_rd_addr,
   output word_data_t        creg_rd_data,
   pipe_ctrl_if.slave        mem_wb,
   output logic              if_stall,
   output logic              id_stall,
   output logic              ex_stall,
   output logic              mem_stall,
   output logic              if_flush,
   output logic              id_flush,
   output logic              ex_flush,
   output logic              mem_flush,
   output word_addr_t        new_pc,
   output logic              exe_mode,
   output logic              int_detect
);

   logic       stall;
   logic       mem_valid;
   logic       exp_take;
   isa_exp_t   exp_code;
   logic       exrt_take;
   logic       wrcr_take;
   logic       redirect;
   word_addr_t epc;
   word_addr_t exp_vector;

   logic unused_gpr_we;
   assign unused_gpr_we = mem_wb.mem_gpr_we_;

   always_comb begin
      stall     = if_busy | mem_busy;
      mem_valid = mem_wb.mem_en & ~stall;
      // A pending interrupt is attached to the next valid instruction without its own fault.
      exp_take  = mem_valid & ((mem_wb.mem_exp_code != ExpNone) | int_detect);
      exp_code  = (mem_wb.mem_exp_code != ExpNone) ? mem_wb.mem_exp_code : ExpExtInt;
      exrt_take = mem_valid & ~exp_take & (mem_wb.mem_ctrl_op == CtrlOpExrt);
      wrcr_take = mem_valid & ~exp_take & ~exrt_take & (mem_wb.mem_ctrl_op == CtrlOpWrcr) &
                  exe_mode;
      redirect  = exp_take | exrt_take;
   end

   always_comb begin
      if_stall  = stall | ld_hazard;
      id_stall  = stall | ld_hazard;
      ex_stall  = stall;
      mem_stall = stall;
      if_flush  = redirect;
      // Load-use: hold IF/ID and push a bubble into ID/EX.
      id_flush  = redirect | (ld_hazard & ~stall);
      ex_flush  = redirect;
      mem_flush = redirect;
      new_pc    = '0;
      if (exp_take) begin
         new_pc = exp_vector;
      end else if (exrt_take) begin
         new_pc = epc;
      end
   end

   pipe_creg_file #(
      .IRQ_CH       (IRQ_CH),
      .RESET_VECTOR (RESET_VECTOR)
   ) u_creg_file (
      .clk           (clk),
      .reset         (reset),
      .irq_i         (irq),
      .rd_addr_i     (creg_rd_addr),
      .rd_data_o     (creg_rd_data),
      .exp_take_i    (exp_take),
      .exp_code_i    (exp_code),
      .exp_pc_i      (mem_wb.mem_pc),
      .exp_br_flag_i (mem_wb.mem_br_flag),
      .exrt_take_i   (exrt_take),
      .wr_en_i       (wrcr_take),
      .wr_addr_i     (mem_wb.mem_dst_addr),
      .wr_data_i     (mem_wb.mem_out),
      .exe_mode_o    (exe_mode),
      .int_detect_o  (int_detect),
      .epc_o         (epc),
      .exp_vector_o  (exp_vector)
   );

endmodule
